// File: rtl/dec_nto2n_seq.sv
// rtl/dec_nto2n_seq.sv - registered N-to-2^N one-hot decoder with valid/ready handshakes and self-driven sweep
module dec_nto2n_seq #(
    parameter int N          = 4,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int STEP_GAP   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic                start,
    input  logic                abort,
    input  logic                in_valid,
    input  logic [N-1:0]        in_code,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [(1<<N)-1:0]   out_onehot,
    output logic [N-1:0]        out_code,
    output logic                busy,
    output logic                sweep_done
);
    localparam int             W        = 1 << N;
    localparam logic [W-1:0]   INACTIVE = {W{ACTIVE_LOW}};
    localparam logic [7:0]     GAP_INIT = 8'(STEP_GAP);
    localparam logic [N-1:0]   LAST     = '1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SWEEP     = 2'd1,
        ST_WAIT_LAST = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_cnt;
    logic [N-1:0]   w_cnt_nxt;
    logic [7:0]     r_gap;
    logic [7:0]     w_gap_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           r_out_valid;
    logic [N-1:0]   r_out_code;
    logic [W-1:0]   r_onehot;

    logic           w_slot_free;
    logic           w_dir_load;
    logic           w_swp_load;
    logic           w_load;
    logic           w_flush;
    logic [N-1:0]   w_load_code;
    logic [W-1:0]   w_dec;

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = (r_state == ST_IDLE) && !mode && w_slot_free && rst_n;
    assign busy        = (r_state != ST_IDLE);
    assign out_valid   = r_out_valid;
    assign out_code    = r_out_code;
    assign out_onehot  = r_onehot;
    assign sweep_done  = r_done;

    // Abort wins over a same-cycle load and over the final handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_done_nxt  = 1'b0;
        w_dir_load  = 1'b0;
        w_swp_load  = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_dir_load = in_valid && in_ready;
                if (mode && start) begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                    w_gap_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end else if (r_gap != 8'd0) begin
                    w_gap_nxt = r_gap - 8'd1;
                end else if (w_slot_free) begin
                    w_swp_load = 1'b1;
                    if (r_cnt == LAST) begin
                        w_state_nxt = ST_WAIT_LAST;
                    end else begin
                        w_cnt_nxt = r_cnt + N'(1);
                        w_gap_nxt = GAP_INIT;
                    end
                end
            end
            ST_WAIT_LAST: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end else if (r_out_valid && out_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_load      = w_dir_load || w_swp_load;
    assign w_load_code = w_swp_load ? r_cnt : in_code;

    always_comb begin
        w_dec              = '0;
        w_dec[w_load_code] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_onehot    <= INACTIVE;
        end else if (w_flush) begin
            r_out_valid <= 1'b0;
            r_onehot    <= INACTIVE;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_code  <= w_load_code;
            r_onehot    <= w_dec ^ INACTIVE;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_onehot    <= INACTIVE;
        end
    end

endmodule

// File: doc/dec_nto2n_seq.md
Name: dec_nto2n_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. It is the sequential successor to the team's fixed 4-input combinational decode/logic-function blocks.
- Adds valid/ready handshakes on both sides, an optional active-low (one-cold) output, and a self-driven SWEEP mode that walks every code 0..2^N-1.
- Used as the decode stage in front of the circuit test harness and as an exhaustive-pattern generator for combinational DUT checks.

Parameters:
- N, 4, input code width; output width is 2^N (N = 1..8).
- ACTIVE_LOW, 0, 1 = selected output bit is 0 and all others are 1; also sets the inactive pattern to all-ones.
- STEP_GAP, 0, idle cycles inserted between successive sweep loads (0..255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- mode  in  1  0 = DIRECT, 1 = SWEEP; sampled only in IDLE.
- start  in  1  sweep start request.
- abort  in  1  terminates an active sweep.
- in_valid  in  1  input code valid.
- in_code  in  N  code to decode.
- in_ready  out  1  input accept.
- out_valid  out  1  output register holds a code.
- out_ready  in  1  downstream accept.
- out_onehot  out  2^N  decoded value.
- out_code  out  N  code held in the output register.
- busy  out  1  high in SWEEP or WAIT_LAST.
- sweep_done  out  1  one-cycle pulse at completion of a sweep.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE; out_valid = 0; out_code = 0.
  - out_onehot = inactive pattern (all 0, or all 1 if ACTIVE_LOW).
  - sweep counter and gap counter = 0; sweep_done = 0.
  - in_ready = 0 while rst_n = 0. Reset mid-sweep abandons the sweep with no sweep_done.
- Output register (one entry):
  - slot_free = !out_valid || out_ready.
  - A load sets out_valid = 1, out_code = code, and out_onehot = (1 << code), inverted if ACTIVE_LOW.
  - If out_valid && out_ready and no load occurs, out_valid -> 0 and out_onehot -> inactive pattern.
  - Whenever out_valid = 0, out_onehot is exactly the inactive pattern.
- DIRECT mode:
  - in_ready = (state == IDLE) && (mode == 0) && slot_free && rst_n. This is combinational from registered state plus out_ready/mode.
  - Transfer occurs on in_valid && in_ready; the output loads on the same edge, so the result is visible after 1 cycle of latency.
  - Back-to-back transfers sustain 1 code/cycle when out_ready is held high.
- FSM states: IDLE, SWEEP, WAIT_LAST.
  - IDLE -> SWEEP when mode = 1 && start = 1. Sets counter = 0 and gap = 0. If both mode = 0 and start = 1, start is ignored.
  - SWEEP: when gap == 0 and slot_free, load counter into the output register.
    - If counter != 2^N-1: counter++ and gap = STEP_GAP.
    - If counter == 2^N-1: go to WAIT_LAST.
    - gap decrements each cycle while nonzero.
  - WAIT_LAST: on out_valid && out_ready, pulse sweep_done for that cycle (registered; visible the next cycle) and go to IDLE.
  - abort in SWEEP or WAIT_LAST: go to IDLE next cycle, clear out_valid, set out_onehot inactive, no sweep_done. Abort has priority over a load in the same cycle. Abort in IDLE is ignored.
  - start while busy is ignored. mode changes while busy are ignored until IDLE. in_ready = 0 whenever busy.
- Counter width is N bits. The sweep terminates at 2^N-1 with no wrap to 0. For N = 1 the sweep emits codes 0 and 1.
- Output stall (out_ready = 0) freezes the sweep; gap counting still proceeds.

Test Plan:
1. N=4, DIRECT, out_ready=1, in_code 0,5,15 on consecutive cycles -> out_onehot 0x0001, 0x0020, 0x8000 one cycle after each; out_valid high for 3 cycles, then 0 with out_onehot=0x0000.
2. DIRECT with out_ready=0 after first transfer: in_code=3 then in_code=9 -> in_ready drops, out_onehot holds 0x0008. Raise out_ready -> 9 accepted, out_onehot=0x0200 next cycle.
3. N=4, STEP_GAP=0, SWEEP start, out_ready=1 -> out_code 0..15 on 16 consecutive cycles, out_onehot=1<<k; sweep_done one pulse after code 15 handshake; busy low afterwards.
4. N=3, STEP_GAP=2, ACTIVE_LOW=1 -> loads every 3 cycles; code 2 gives out_onehot=8'hFB; inactive=8'hFF between loads.
5. Sweep with abort asserted while out_code=6 -> next cycle state IDLE, out_valid=0, no sweep_done; in_valid in DIRECT accepted the following cycle.
6. rst_n=0 mid-sweep (code 9 held) -> after the edge out_valid=0, busy=0, out_onehot inactive, in_ready=0 during reset; after release, a new sweep starts from code 0.
